// File: rtl/cam_pkg.sv
// Shared types and default timing for the DVP pattern source and capture benches.
// Holds the FSM/pattern enums, the RGB565 bar palette and a width helper.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } cam_gen_state_t;

    typedef enum logic [1:0] {
        PAT_RAMP,
        PAT_BARS,
        PAT_CHECK,
        PAT_TAG
    } cam_pattern_t;

    localparam logic [15:0] CAM_BAR_RGB [0:7] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    localparam int CAM_H_ACTIVE    = 640;
    localparam int CAM_V_ACTIVE    = 480;
    localparam int CAM_BPP         = 2;
    localparam int CAM_H_BLANK     = 144;
    localparam int CAM_VSYNC_LINES = 3;
    localparam int CAM_V_BACK      = 17;
    localparam int CAM_V_FRONT     = 10;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cam_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_pattern_pixel.sv
// Combinational 16-bit test pixel for the selected pattern.
// Bar index comes from the caller's segment counter, so no divider here.
module cam_pattern_pixel
    import cam_pkg::*;
(
    input  cam_pattern_t pattern_i,
    input  logic [15:0]  x_i,
    input  logic [7:0]   y_i,
    input  logic [2:0]   bar_i,
    input  logic [7:0]   frame_i,
    output logic [15:0]  pixel_o
);

    // Pixel value selected by the latched pattern.
    always_comb begin
        pixel_o = '0;
        unique case (pattern_i)
            PAT_RAMP:  pixel_o = x_i;
            PAT_BARS:  pixel_o = CAM_BAR_RGB[bar_i];
            PAT_CHECK: pixel_o = (x_i[5] ^ y_i[5]) ? 16'hFFFF : 16'h0000;
            PAT_TAG:   pixel_o = {frame_i, y_i};
        endcase
    end

endmodule

// File: rtl/cam_dvp_pattern_gen.sv
// DVP sensor emulator: OV7670-style vsync/href/data timing on pclk.
// Outputs are registered from next-state values so they line up with the FSM.
module cam_dvp_pattern_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = CAM_H_ACTIVE,
    parameter int V_ACTIVE    = CAM_V_ACTIVE,
    parameter int BPP         = CAM_BPP,
    parameter int H_BLANK     = CAM_H_BLANK,
    parameter int VSYNC_LINES = CAM_VSYNC_LINES,
    parameter int V_BACK      = CAM_V_BACK,
    parameter int V_FRONT     = CAM_V_FRONT
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cam_href,
    output logic        cam_vsync,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int LINE_PERIOD = H_ACTIVE * BPP + H_BLANK;
    localparam int VS_LEN = VSYNC_LINES * LINE_PERIOD;
    localparam int VB_LEN = V_BACK * LINE_PERIOD;
    localparam int VF_LEN = V_FRONT * LINE_PERIOD;
    localparam int MAX_A = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
    localparam int MAX_B = (VF_LEN > H_BLANK) ? VF_LEN : H_BLANK;
    localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int SEG = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam int CW = cam_bits(MAX_LEN);
    localparam int XW = cam_bits(H_ACTIVE);
    localparam int YW = cam_bits(V_ACTIVE);
    localparam int BW = cam_bits(BPP);
    localparam int SW = cam_bits(SEG);

    localparam logic [CW-1:0] VS_LAST = CW'(VS_LEN - 1);
    localparam logic [CW-1:0] VB_LAST = CW'(VB_LEN - 1);
    localparam logic [CW-1:0] VF_LAST = CW'(VF_LEN - 1);
    localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BPP - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(SEG - 1);

    cam_gen_state_t state_q, state_d;
    cam_pattern_t   pat_q, pat_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [BW-1:0]  b_q, b_d;
    logic [SW-1:0]  seg_q, seg_d;
    logic [2:0]     bar_q, bar_d;

    logic           href_q, href_d;
    logic           vsync_q, vsync_d;
    logic [7:0]     data_q, data_d;
    logic           done_q, done_d;
    logic [15:0]    fcount_q;
    logic [15:0]    pixel;

    cam_pattern_pixel u_pixel (
        .pattern_i (pat_d),
        .x_i       (16'(x_d)),
        .y_i       (8'(y_d)),
        .bar_i     (bar_d),
        .frame_i   (fcount_q[7:0]),
        .pixel_o   (pixel)
    );

    // Next-state, counters and next output values.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        b_d     = b_q;
        seg_d   = seg_q;
        bar_d   = bar_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_VSYNC;
                    cnt_d   = '0;
                    pat_d   = cam_pattern_t'(pattern_sel);
                end
            end
            ST_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = ST_VBACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_VBACK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    b_d     = '0;
                    seg_d   = '0;
                    bar_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACTIVE: begin
                if (b_q == B_LAST) begin
                    b_d = '0;
                    if (x_q == X_LAST) begin
                        state_d = ST_HBLANK;
                        cnt_d   = '0;
                    end else begin
                        x_d = x_q + XW'(1);
                        if (seg_q == S_LAST) begin
                            seg_d = '0;
                            bar_d = bar_q + 3'd1;
                        end else begin
                            seg_d = seg_q + SW'(1);
                        end
                    end
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_VFRONT;
                    end else begin
                        state_d = ST_ACTIVE;
                        y_d     = y_q + YW'(1);
                        x_d     = '0;
                        b_d     = '0;
                        seg_d   = '0;
                        bar_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_VFRONT: begin
                if (cnt_q == VF_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = ST_VSYNC;
                        pat_d   = cam_pattern_t'(pattern_sel);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        href_d  = (state_d == ST_ACTIVE);
        vsync_d = (state_d == ST_VSYNC);
        done_d  = (state_d == ST_VFRONT) && (cnt_d == VF_LAST);
        data_d  = '0;
        if (href_d) begin
            data_d = (BPP > 1 && b_d == '0) ? pixel[15:8] : pixel[7:0];
        end
    end

    // State, counters and registered DVP outputs.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pat_q    <= PAT_RAMP;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            b_q      <= '0;
            seg_q    <= '0;
            bar_q    <= '0;
            href_q   <= 1'b0;
            vsync_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            fcount_q <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            b_q     <= b_d;
            seg_q   <= seg_d;
            bar_q   <= bar_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
            data_q  <= data_d;
            done_q  <= done_d;
            if (done_d) begin
                fcount_q <= fcount_q + 16'd1;
            end
        end
    end

    assign cam_href    = href_q;
    assign cam_vsync   = vsync_q;
    assign cam_data    = data_q;
    assign frame_done  = done_q;
    assign frame_count = fcount_q;

endmodule

// File: tb/tb_cam_dvp_pattern_gen.sv
// Bench for the DVP pattern source: frame-level reference model feeds a byte
// scoreboard; a negedge monitor checks bytes, sync timing and frame_done.
module tb_cam_dvp_pattern_gen;

    localparam int HA  = 8;
    localparam int VA  = 4;
    localparam int BPP = 2;
    localparam int HB  = 4;
    localparam int VSL = 1;
    localparam int VBK = 1;
    localparam int VFR = 1;
    localparam int LP    = HA * BPP + HB;
    localparam int FRAME = (VSL + VBK + VA + VFR) * LP;
    localparam int NFR   = 11;

    localparam logic [15:0] BARS [0:7] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        cam_href;
    logic        cam_vsync;
    logic [7:0]  cam_data;
    logic        frame_done;
    logic [15:0] frame_count;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int fc_model = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] done_q [$];

    cam_dvp_pattern_gen #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .BPP         (BPP),
        .H_BLANK     (HB),
        .VSYNC_LINES (VSL),
        .V_BACK      (VBK),
        .V_FRONT     (VFR)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .cam_data    (cam_data),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (cyc > 30000) begin
            $display("FAIL watchdog: cycle %0d exceeds budget 30000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_pixel(input int sel, input int x,
                                              input int y, input int f);
        case (sel)
            0: return 16'(x);
            1: return BARS[x / (HA / 8)];
            2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return {8'(f), 8'(y)};
        endcase
    endfunction

    task automatic push_frame(input int sel, input int f);
        logic [15:0] p;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                p = ref_pixel(sel, x, y, f);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
        done_q.push_back(16'(f + 1));
    endtask

    int vs_start = 0;
    int vs_fall = 0;
    int hr_rise = 0;
    int hr_fall = 0;
    int line_idx = 0;
    logic prev_vs = 1'b0;
    logic prev_hr = 1'b0;
    logic [7:0]  exp_b;
    logic [15:0] exp_fc;

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a frame end.
    always @(negedge pclk) begin
        if (!reset_n) begin
            prev_vs  = 1'b0;
            prev_hr  = 1'b0;
            line_idx = 0;
        end else begin
            if (cam_vsync && !prev_vs) begin
                vs_start = cyc;
                line_idx = 0;
            end
            if (!cam_vsync && prev_vs) begin
                check("vsync_len", cyc - vs_start, VSL * LP);
                vs_fall = cyc;
            end
            if (cam_href && !prev_hr) begin
                if (line_idx == 0)
                    check("vback_gap", cyc - vs_fall, VBK * LP);
                else
                    check("hblank_gap", cyc - hr_fall, HB);
                hr_rise = cyc;
            end
            if (!cam_href && prev_hr) begin
                check("href_len", cyc - hr_rise, HA * BPP);
                hr_fall = cyc;
                line_idx++;
            end
            if (cam_href) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL data: byte %0h with empty scoreboard", cam_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("data", cam_data, exp_b);
                end
            end else begin
                check("blank_data", cam_data, 0);
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL frame_done: unexpected pulse, count %0h", frame_count);
                end else begin
                    exp_fc = done_q.pop_front();
                    check("frame_count", frame_count, exp_fc);
                    check("frame_len", cyc - vs_start, FRAME - 1);
                    check("lines", line_idx, VA);
                end
            end
            prev_vs = cam_vsync;
            prev_hr = cam_href;
        end
    end

    initial begin
        int sel;
        int mid_at;
        bit drop;
        bit rst_mid;
        bit aborted;

        repeat (3) @(negedge pclk);
        check("rst_href", cam_href, 0);
        check("rst_vsync", cam_vsync, 0);
        check("rst_data", cam_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", frame_count, 0);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            check("idle_vsync", cam_vsync, 0);
        end

        for (int fr = 0; fr < NFR; fr++) begin
            case (fr)
                0: sel = 0;
                1: sel = 2;
                2: sel = 3;
                3: sel = 1;
                default: sel = int'($urandom_range(0, 3));
            endcase
            drop    = (fr == 4) || (fr >= 6 && $urandom_range(0, 3) == 0);
            rst_mid = (fr == 5);
            mid_at  = int'($urandom_range(1, 130));
            aborted = 1'b0;
            pattern_sel = 2'(sel);
            enable = 1'b1;
            push_frame(sel, fc_model);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge pclk);
                if (i == mid_at)
                    pattern_sel = (fr == 0) ? 2'd2 : 2'($urandom_range(0, 3));
                if (drop && i == 85)
                    enable = 1'b0;
                if (rst_mid && i == 70) begin
                    #1 reset_n = 1'b0;
                    #1;
                    check("async_href", cam_href, 0);
                    check("async_vsync", cam_vsync, 0);
                    check("async_data", cam_data, 0);
                    check("async_count", frame_count, 0);
                    exp_q.delete();
                    done_q.delete();
                    fc_model = 0;
                    @(negedge pclk);
                    #1 reset_n = 1'b1;
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                fc_model++;
                if (drop) begin
                    repeat (8) begin
                        @(negedge pclk);
                        check("drop_vsync", cam_vsync, 0);
                        check("drop_href", cam_href, 0);
                        check("drop_count", frame_count, fc_model);
                    end
                end
            end
        end

        enable = 1'b0;
        repeat (LP) @(negedge pclk);
        check("bytes_left", exp_q.size(), 0);
        check("frames_left", done_q.size(), 0);
        check("final_count", frame_count, fc_model);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cam_dvp_pattern_gen.md
Name: cam_dvp_pattern_gen

Overview:
- Synthesizable DVP camera-side source: drives cam_vsync, cam_href and cam_data with the byte stream and timing an OV7670-class sensor emits, clocked by pclk.
- Feeds cam_capture in place of the physical sensor for board bring-up, BRAM/HDMI path checks and regression benches.
- Output bytes are deterministic test patterns, so the captured frame can be checked pixel-exactly.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BPP, 2, bytes per pixel (RGB565; high byte first)
- H_BLANK, 144, href-low cycles after each line's active bytes
- VSYNC_LINES, 3, line periods with cam_vsync high
- V_BACK, 17, line periods between vsync fall and first active line
- V_FRONT, 10, line periods after last active line (must be >=1)

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run frames continuously while high
- pattern_sel  in  2  0 ramp, 1 colour bars, 2 checkerboard, 3 frame tag
- cam_href  out  1  line-valid, registered
- cam_vsync  out  1  frame sync, active-high, registered
- cam_data  out  8  pixel byte, registered; 0 whenever cam_href low
- frame_done  out  1  one-cycle pulse at end of each frame
- frame_count  out  16  completed frames, wraps 0xFFFF->0x0000

Behaviour:
- LINE_PERIOD = H_ACTIVE*BPP + H_BLANK cycles.
- Frame = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_PERIOD cycles.
- Reset (async, any time, incl. mid-line): state IDLE; all outputs 0; counters 0.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
- IDLE: outputs low. At the first edge with enable=1, go to VSYNC and set cam_vsync=1 on that edge.
- pattern_sel is latched on IDLE->VSYNC and VFRONT->VSYNC edges only. Mid-frame changes are ignored.
- VSYNC: cam_vsync high for VSYNC_LINES*LINE_PERIOD cycles, then VBACK.
- VBACK: all outputs low for V_BACK*LINE_PERIOD cycles, then ACTIVE with line y=0.
- ACTIVE: cam_href high for H_ACTIVE*BPP cycles; byte index b counts 0..BPP-1 within pixel x=0..H_ACTIVE-1. Then HBLANK.
- HBLANK: href low for H_BLANK cycles. Then y++ and back to ACTIVE, or VFRONT if y was V_ACTIVE-1.
- VFRONT: lasts V_FRONT*LINE_PERIOD cycles.
  - On its final cycle, frame_done=1 and frame_count increments on the same edge.
  - Next state is VSYNC if enable=1, otherwise IDLE.
- enable falling mid-frame: the current frame completes; it never truncates.
- Pixel value p(x,y,f) is 16-bit; byte b=0 is p[15:8], b=1 is p[7:0]. For BPP=1, only p[7:0] is sent.
  - 0 ramp: p = zero-extended x.
  - 1 colour bars: bar = x / (H_ACTIVE/8), computed with a segment counter (no divider). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2 checkerboard: p = (x[5]^y[5]) ? FFFF : 0000.
  - 3 frame tag: p = {frame_count[7:0], y[7:0]}.
- Throughput: one byte per pclk during ACTIVE; no backpressure.

Decomposition:
- Shared package cam_pkg:
  - state enum cam_gen_state_t
  - pattern enum cam_pattern_t
  - RGB565 colour-bar constant array
  - default timing localparams, also used by cam_capture benches
- One sub-module, cam_pattern_pixel: combinational p from (pattern, x, y, bar, frame_count). The FSM, counters and output registers stay in the top.

Test Plan:
- Small params H_ACTIVE=8, V_ACTIVE=4, BPP=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, so LINE_PERIOD=20.
  - Frame 0: reset_n low, then high with enable=1, sel=0 -> vsync high 20 cycles; then 20 idle cycles; then 4 lines of href-high 16 cycles each. Line bytes are 00 00 00 01 ... 00 07, with 4 blank cycles after each line.
  - frame_done pulses once after 140 cycles; frame_count reads 1.
- sel=1, same params -> each line carries FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
- sel=3 on frame 2 -> every byte pair is {02, y}, e.g. line 3 gives 02 03 repeated 8 times.
- Change pattern_sel 0->2 mid-frame -> that frame stays ramp; the next frame is checkerboard (all 0000 for x,y<32).
- enable dropped during line 2 -> frame completes; frame_done pulses; FSM goes to IDLE with vsync, href and data held 0.
- reset_n pulsed low mid-ACTIVE -> outputs 0 asynchronously; frame_count=0. On release with enable=1, a full frame restarts at VSYNC.
